// File: rtl/next_pc_pkg.sv
// Shared definitions for the next-PC generator: default sizes and the
// encoding of which redirect source won arbitration in a given cycle.
package next_pc_pkg;

    localparam int AW_DEF        = 20;
    localparam int RAS_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_BR   = 3'd1,
        SRC_JMP  = 3'd2,
        SRC_CALL = 3'd3,
        SRC_RET  = 3'd4
    } src_e;

    // Fixed priority ret > call > jump > branch; only the winner is acted on.
    function automatic src_e pick_src(input logic ret, input logic call,
                                      input logic jump, input logic br_taken);
        src_e s;
        s = SRC_NONE;
        if (ret)           s = SRC_RET;
        else if (call)     s = SRC_CALL;
        else if (jump)     s = SRC_JMP;
        else if (br_taken) s = SRC_BR;
        return s;
    endfunction

endpackage

// File: rtl/next_pc_ras.sv
// Circular return-address stack. A push when full overwrites the oldest entry;
// a simultaneous push+pop replaces the top in place.
module next_pc_ras #(
    parameter int AW    = 20,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top,
    output logic          empty,
    output logic          full,
    output logic          ovf_evt,
    output logic          unf_evt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem_reg [DEPTH];
    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [PW-1:0] top_idx;
    logic [PW-1:0] wr_idx;
    logic          wr_en;
    logic [DEPTH-1:0] wr_hit;

    // ptr_reg is the next free slot, so the top lives one below it.
    assign top_idx = ptr_reg - PW'(1);
    assign top     = mem_reg[top_idx];
    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));

    assign ovf_evt = push && !pop && full;
    assign unf_evt = pop && empty;

    assign wr_en  = push;
    assign wr_idx = (push && pop) ? top_idx : ptr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign wr_hit[gi] = wr_en && (wr_idx == PW'(gi));
        end
    endgenerate

    always_comb begin
        ptr_next   = ptr_reg;
        count_next = count_reg;
        if (push && !pop) begin
            ptr_next = ptr_reg + PW'(1);
            if (!full) count_next = count_reg + CW'(1);
        end else if (pop && !push) begin
            if (!empty) begin
                ptr_next   = ptr_reg - PW'(1);
                count_next = count_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg   <= '0;
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else begin
            ptr_reg   <= ptr_next;
            count_reg <= count_next;
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_hit[i]) mem_reg[i] <= push_data;
            end
        end
    end

endmodule

// File: rtl/next_pc_gen.sv
// Next-PC selection: sequential fetch, branch/jump/call/return redirects,
// return-address stack and a pending slot that parks a redirect across stalls.
module next_pc_gen
    import next_pc_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc,
    input  logic          stall,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    input  logic          jump,
    input  logic [AW-1:0] jump_target,
    input  logic          call,
    input  logic          ret,
    input  logic [AW-1:0] ret_reg,
    output logic [AW-1:0] next,
    output logic          redirect,
    output logic          ras_ovf,
    output logic          ras_unf
);

    src_e          src;
    logic          take_new;
    logic          ras_push;
    logic          ras_pop;
    logic [AW-1:0] seq_pc;
    logic [AW-1:0] target;
    logic [AW-1:0] ras_top;
    logic          ras_empty;
    logic          ras_full;
    logic          ovf_evt;
    logic          unf_evt;

    logic          pend_valid_reg;
    logic          pend_valid_next;
    logic [AW-1:0] pend_target_reg;
    logic [AW-1:0] pend_target_next;
    logic          ras_ovf_reg;
    logic          ras_unf_reg;

    assign src    = pick_src(ret, call, jump, br_taken);
    assign seq_pc = pc + AW'(1);

    // A parked redirect makes every new redirect wrong-path, including its RAS op.
    assign take_new = (src != SRC_NONE) && !pend_valid_reg;
    assign ras_push = take_new && call;
    assign ras_pop  = take_new && ret;

    always_comb begin
        target = seq_pc;
        case (src)
            SRC_RET:  target = ras_empty ? ret_reg : ras_top;
            SRC_CALL: target = jump_target;
            SRC_JMP:  target = jump_target;
            SRC_BR:   target = br_target;
            default:  target = seq_pc;
        endcase
    end

    next_pc_ras #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .ovf_evt   (ovf_evt),
        .unf_evt   (unf_evt)
    );

    always_comb begin
        next             = seq_pc;
        redirect         = 1'b0;
        pend_valid_next  = pend_valid_reg;
        pend_target_next = pend_target_reg;
        if (!rst) begin
            next     = '0;
            redirect = 1'b0;
        end else if (pend_valid_reg) begin
            if (!stall) begin
                next            = pend_target_reg;
                redirect        = 1'b1;
                pend_valid_next = 1'b0;
            end else begin
                next = pc;
            end
        end else if (take_new) begin
            if (stall) begin
                next             = pc;
                pend_valid_next  = 1'b1;
                pend_target_next = target;
            end else begin
                next     = target;
                redirect = 1'b1;
            end
        end else if (stall) begin
            next = pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid_reg  <= 1'b0;
            pend_target_reg <= '0;
            ras_ovf_reg     <= 1'b0;
            ras_unf_reg     <= 1'b0;
        end else begin
            pend_valid_reg  <= pend_valid_next;
            pend_target_reg <= pend_target_next;
            if (ovf_evt) ras_ovf_reg <= 1'b1;
            if (unf_evt) ras_unf_reg <= 1'b1;
        end
    end

    assign ras_ovf = ras_ovf_reg;
    assign ras_unf = ras_unf_reg;

    // Full status is implied by ovf_evt; kept visible for debug probing.
    logic ras_full_unused;
    assign ras_full_unused = ras_full;

endmodule

// File: tb/tb_next_pc_gen.sv
// Directed bench for next_pc_gen: reset, sequential/wrap, call/return,
// RAS overflow/underflow, stalled redirects and wrong-path suppression.
module tb_next_pc_gen;

    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] pc = '0;
    logic          stall = 1'b0;
    logic          br_taken = 1'b0;
    logic [AW-1:0] br_target = '0;
    logic          jump = 1'b0;
    logic [AW-1:0] jump_target = '0;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic [AW-1:0] ret_reg = '0;
    logic [AW-1:0] next;
    logic          redirect;
    logic          ras_ovf;
    logic          ras_unf;

    int n_chk  = 0;
    int n_fail = 0;

    next_pc_gen #(.AW(AW), .RAS_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jump        (jump),
        .jump_target (jump_target),
        .call        (call),
        .ret         (ret),
        .ret_reg     (ret_reg),
        .next        (next),
        .redirect    (redirect),
        .ras_ovf     (ras_ovf),
        .ras_unf     (ras_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic idle();
        stall    = 1'b0;
        br_taken = 1'b0;
        jump     = 1'b0;
        call     = 1'b0;
        ret      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state, with inputs that would otherwise produce a redirect
        pc = 20'h00005; jump = 1'b1; jump_target = 20'h00777;
        #2;
        chk("rst_next", 32'(next), 32'h0);
        chk("rst_redirect", 32'(redirect), 32'h0);
        chk("rst_ovf", 32'(ras_ovf), 32'h0);
        chk("rst_unf", 32'(ras_unf), 32'h0);
        idle();
        tick();
        rst = 1'b1;
        #1;

        // Sequential and wrap
        pc = 20'h00010; #1;
        chk("seq_next", 32'(next), 32'h00011);
        chk("seq_redirect", 32'(redirect), 32'h0);
        pc = 20'hFFFFF; #1;
        chk("wrap_next", 32'(next), 32'h00000);
        chk("wrap_redirect", 32'(redirect), 32'h0);

        // Basic call / return
        pc = 20'h00100; call = 1'b1; jump_target = 20'h00400; #1;
        chk("call_next", 32'(next), 32'h00400);
        chk("call_redirect", 32'(redirect), 32'h1);
        tick(); idle();
        pc = 20'h00400; ret = 1'b1; ret_reg = 20'h0DEAD; #1;
        chk("ret_next", 32'(next), 32'h00101);
        chk("ret_redirect", 32'(redirect), 32'h1);
        tick(); idle();

        // Priority: jump beats branch
        pc = 20'h00020; br_taken = 1'b1; br_target = 20'h00222;
        jump = 1'b1; jump_target = 20'h00333; #1;
        chk("prio_jmp_over_br", 32'(next), 32'h00333);
        tick(); idle();

        // Nested depth 4 unwinds LIFO, no overflow
        for (int i = 0; i < 4; i++) begin
            pc = AW'(32'h10 * (i + 1)); call = 1'b1; jump_target = 20'h00800; #1;
            chk("nest_call", 32'(next), 32'h00800);
            tick(); idle();
        end
        chk("nest_no_ovf", 32'(ras_ovf), 32'h0);
        for (int i = 0; i < 4; i++) begin
            pc = 20'h00800; ret = 1'b1; #1;
            chk("nest_ret", 32'(next), 32'h10 * (4 - i) + 1);
            tick(); idle();
        end
        chk("nest_no_unf", 32'(ras_unf), 32'h0);

        // Overflow: 5 calls, the oldest (0x01001) is lost
        for (int i = 0; i < 5; i++) begin
            pc = AW'(32'h01000 + 32'h10 * i); call = 1'b1; jump_target = 20'h02000; #1;
            tick(); idle();
        end
        chk("ovf_flag", 32'(ras_ovf), 32'h1);
        ret_reg = 20'h0ABCD;
        for (int i = 0; i < 5; i++) begin
            pc = 20'h02000; ret = 1'b1; #1;
            if (i < 4) chk("ovf_ret", 32'(next), 32'h01041 - 32'h10 * i);
            else       chk("unf_ret_reg", 32'(next), 32'h0ABCD);
            tick(); idle();
        end
        chk("unf_flag", 32'(ras_unf), 32'h1);
        chk("ovf_sticky", 32'(ras_ovf), 32'h1);

        // Stalled branch is parked, then released
        pc = 20'h00050; stall = 1'b1; br_taken = 1'b1; br_target = 20'h00200; #1;
        chk("stall_br_next", 32'(next), 32'h00050);
        chk("stall_br_redirect", 32'(redirect), 32'h0);
        tick(); br_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_hold", 32'(next), 32'h00050);
            tick();
        end
        stall = 1'b0; #1;
        chk("release_next", 32'(next), 32'h00200);
        chk("release_redirect", 32'(redirect), 32'h1);
        tick();
        pc = 20'h00200; #1;
        chk("after_release_seq", 32'(next), 32'h00201);
        chk("after_release_redirect", 32'(redirect), 32'h0);

        // Wrong-path: jump+call while pending are ignored, call does not push
        pc = 20'h00060; stall = 1'b1; br_taken = 1'b1; br_target = 20'h00200; #1;
        tick(); br_taken = 1'b0;
        jump = 1'b1; call = 1'b1; jump_target = 20'h00300; #1;
        chk("wp_stalled_next", 32'(next), 32'h00060);
        tick();
        stall = 1'b0; call = 1'b0; jump = 1'b1; jump_target = 20'h00300; #1;
        chk("wp_release_next", 32'(next), 32'h00200);
        tick(); idle();
        pc = 20'h00200; ret = 1'b1; ret_reg = 20'h0BEEF; #1;
        chk("wp_no_push", 32'(next), 32'h0BEEF);
        tick(); idle();

        // Reset mid-stream while a redirect is pending
        pc = 20'h00070; call = 1'b1; jump_target = 20'h00900; #1;
        tick(); idle();
        pc = 20'h00900; stall = 1'b1; jump = 1'b1; jump_target = 20'h00A00; #1;
        tick(); idle(); stall = 1'b1;
        #1 rst = 1'b0; #1;
        chk("mid_rst_next", 32'(next), 32'h0);
        chk("mid_rst_ovf", 32'(ras_ovf), 32'h0);
        chk("mid_rst_unf", 32'(ras_unf), 32'h0);
        tick();
        rst = 1'b1; stall = 1'b0; pc = 20'h00070; #1;
        chk("post_rst_pend_clear", 32'(next), 32'h00071);
        chk("post_rst_redirect", 32'(redirect), 32'h0);
        ret = 1'b1; ret_reg = 20'h12345; #1;
        chk("post_rst_ras_empty", 32'(next), 32'h12345);
        tick(); idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
